// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: memory op encodings, exception codes and byte-enable constants
// shared by the MEM-stage access unit and its load extender.
package mem_access_unit_pkg;

   localparam int         DM_ADDR_BITS = 13;
   localparam logic [4:0] EXC_ADEL     = 5'd4;
   localparam logic [4:0] EXC_ADES     = 5'd5;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_HI   = 4'b1100;
   localparam logic [3:0] BE_BYTE = 4'b0001;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LW   = 4'd1,
      OP_LH   = 4'd2,
      OP_LHU  = 4'd3,
      OP_LB   = 4'd4,
      OP_LBU  = 4'd5,
      OP_SW   = 4'd6,
      OP_SH   = 4'd7,
      OP_SB   = 4'd8
   } mem_op_e;

   function automatic logic is_load(input logic [3:0] op);
      return op >= OP_LW && op <= OP_LBU;
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op >= OP_SW && op <= OP_SB;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX/MEM inputs, data-memory port and MEM/WB outputs of the access unit.
interface mem_access_unit_if;

   logic        valid_in;
   logic        stall;
   logic        flush;
   logic [3:0]  mem_op;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic [4:0]  rd_in;
   logic [31:0] pc_in;
   logic [31:0] dm_rdata;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_we;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_vaddr;
   logic [31:0] exc_pc;

   modport master (
      output valid_in, stall, flush, mem_op, addr, st_data, rd_in, pc_in, dm_rdata,
      input  dm_addr, dm_be, dm_wdata, dm_we,
      input  wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_vaddr, exc_pc
   );

   modport slave (
      input  valid_in, stall, flush, mem_op, addr, st_data, rd_in, pc_in, dm_rdata,
      output dm_addr, dm_be, dm_wdata, dm_we,
      output wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_vaddr, exc_pc
   );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// mem_access_unit_load_extend: selects the addressed byte/half of the DM read word
// and sign- or zero-extends it according to the load op.
module mem_access_unit_load_extend
   import mem_access_unit_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

   always_comb
      o_data = i_op == OP_LB  ? {{24{w_byte[7]}}, w_byte}  :
               i_op == OP_LBU ? {24'd0, w_byte}            :
               i_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
               i_op == OP_LHU ? {16'd0, w_half}            :
                                i_rdata;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory front end -- byte enables, write strobe,
// AdEL/AdES detection, load extraction and the MEM/WB register.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);

   logic        w_load, w_store, w_word, w_half, w_mis, w_oor, w_fault, w_we;
   logic [3:0]  w_be;
   logic [4:0]  w_code;
   logic [31:0] w_ldata;
   logic        r_st_done;
   logic        r_wb_valid, r_exc_valid;
   logic [4:0]  r_wb_rd, r_exc_code;
   logic [31:0] r_wb_data, r_exc_vaddr, r_exc_pc;

   always_comb begin
      w_load  = is_load(bus.mem_op);
      w_store = is_store(bus.mem_op);
      w_word  = bus.mem_op == OP_LW || bus.mem_op == OP_SW;
      w_half  = bus.mem_op == OP_LH || bus.mem_op == OP_LHU || bus.mem_op == OP_SH;
      w_mis   = (w_word && bus.addr[1:0] != 2'b00) || (w_half && bus.addr[0]);
      w_oor   = |bus.addr[31:DM_ADDR_BITS];
      w_fault = bus.valid_in && (w_mis || w_oor) && (w_load || w_store);
      w_code  = w_store ? EXC_ADES : EXC_ADEL;
      w_be    = bus.mem_op == OP_SW ? BE_WORD :
                bus.mem_op == OP_SH ? (bus.addr[1] ? BE_HI : BE_LO) :
                bus.mem_op == OP_SB ? BE_BYTE << bus.addr[1:0] :
                                      BE_NONE;
      // st_done blocks a second commit of a store that sits in MEM under stall
      w_we    = !reset && bus.valid_in && w_store && !w_fault && !bus.flush && !r_st_done;
   end

   mem_access_unit_load_extend u_ext (
      .i_op    (bus.mem_op),
      .i_addr  (bus.addr[1:0]),
      .i_rdata (bus.dm_rdata),
      .o_data  (w_ldata)
   );

   always_ff @(posedge clk)
      r_st_done <= !reset && bus.stall && !bus.flush && (r_st_done || w_we);

   always_ff @(posedge clk)
      if (reset) begin
         r_wb_valid  <= 1'b0;
         r_wb_rd     <= 5'd0;
         r_wb_data   <= 32'd0;
         r_exc_valid <= 1'b0;
         r_exc_code  <= 5'd0;
         r_exc_vaddr <= 32'd0;
         r_exc_pc    <= 32'd0;
      end else if (!bus.stall) begin
         r_wb_valid  <= bus.valid_in && w_load && !w_fault && !bus.flush;
         r_wb_rd     <= bus.rd_in;
         r_wb_data   <= w_ldata;
         r_exc_valid <= w_fault && !bus.flush;
         r_exc_code  <= w_code;
         r_exc_vaddr <= bus.addr;
         r_exc_pc    <= bus.pc_in;
      end else
         r_exc_valid <= 1'b0;

   assign bus.dm_addr   = bus.addr;
   assign bus.dm_be     = w_be;
   assign bus.dm_wdata  = bus.st_data;
   assign bus.dm_we     = w_we;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_rd     = r_wb_rd;
   assign bus.wb_data   = r_wb_data;
   assign bus.exc_valid = r_exc_valid;
   assign bus.exc_code  = r_exc_code;
   assign bus.exc_vaddr = r_exc_vaddr;
   assign bus.exc_pc    = r_exc_pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a small byte-lane DM model
// and hand-computed expected values.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        r_force;
   logic [31:0] r_forced;
   logic [31:0] mem [16];
   int          we_cnt = 0;
   int          c0;
   int          checks = 0;
   int          failures = 0;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.dm_rdata = r_force ? r_forced : mem[bus.dm_addr[5:2]];

   always @(posedge clk)
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      end else if (bus.dm_we) begin
         we_cnt <= we_cnt + 1;
         for (int i = 0; i < 4; i++)
            if (bus.dm_be[i])
               mem[bus.dm_addr[5:2]][8*i +: 8] <=
                  bus.dm_be == 4'b1111 ? bus.dm_wdata[8*i +: 8] :
                  (bus.dm_be == 4'b0011 || bus.dm_be == 4'b1100) ? bus.dm_wdata[8*(i%2) +: 8] :
                  bus.dm_wdata[7:0];
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input logic [31:0] pc);
      bus.valid_in = 1'b1;
      bus.mem_op   = op;
      bus.addr     = a;
      bus.st_data  = d;
      bus.rd_in    = rd;
      bus.pc_in    = pc;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      r_force = 1'b0;
      r_forced = 32'd0;
      bus.valid_in = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.mem_op = 4'd0;
      bus.addr = 32'd0;
      bus.st_data = 32'd0;
      bus.rd_in = 5'd0;
      bus.pc_in = 32'd0;
      go();
      go();
      chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_exc_valid", {31'd0, bus.exc_valid}, 32'd0);
      chk("rst_exc_code", {27'd0, bus.exc_code}, 32'd0);
      chk("rst_exc_vaddr", bus.exc_vaddr, 32'd0);
      chk("rst_exc_pc", bus.exc_pc, 32'd0);
      drive(4'd6, 32'h0, 32'h0, 5'd0, 32'h0);
      chk("rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
      reset = 1'b0;
      #1;
      chk("sw_be", {28'd0, bus.dm_be}, 32'hF);
      chk("sw_we", {31'd0, bus.dm_we}, 32'd1);
      go();

      drive(4'd8, 32'h13, 32'hAB, 5'd0, 32'h100);
      chk("sb_be", {28'd0, bus.dm_be}, 32'h8);
      chk("sb_we", {31'd0, bus.dm_we}, 32'd1);
      chk("sb_wdata", bus.dm_wdata, 32'hAB);
      chk("sb_addr", bus.dm_addr, 32'h13);
      go();
      drive(4'd7, 32'h6, 32'h1234, 5'd0, 32'h104);
      chk("sh_be", {28'd0, bus.dm_be}, 32'hC);
      chk("sh_we", {31'd0, bus.dm_we}, 32'd1);
      go();
      drive(4'd5, 32'h13, 32'h0, 5'd7, 32'h108);
      chk("lbu_be", {28'd0, bus.dm_be}, 32'h0);
      chk("lbu_we", {31'd0, bus.dm_we}, 32'd0);
      go();
      chk("lbu_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("lbu_wb_rd", {27'd0, bus.wb_rd}, 32'd7);
      chk("lbu_wb_data", bus.wb_data, 32'hAB);
      drive(4'd1, 32'h4, 32'h0, 5'd3, 32'h10C);
      go();
      chk("lw_sh_data", bus.wb_data, 32'h1234_0000);

      r_force = 1'b1;
      r_forced = 32'h80FF_7F01;
      drive(4'd4, 32'h1, 32'h0, 5'd1, 32'h200);
      go();
      chk("lb1", bus.wb_data, 32'h0000_007F);
      drive(4'd4, 32'h3, 32'h0, 5'd1, 32'h204);
      go();
      chk("lb3", bus.wb_data, 32'hFFFF_FF80);
      drive(4'd2, 32'h2, 32'h0, 5'd1, 32'h208);
      go();
      chk("lh2", bus.wb_data, 32'hFFFF_80FF);
      drive(4'd3, 32'h2, 32'h0, 5'd1, 32'h20C);
      go();
      chk("lhu2", bus.wb_data, 32'h0000_80FF);
      drive(4'd5, 32'h0, 32'h0, 5'd1, 32'h210);
      go();
      chk("lbu0", bus.wb_data, 32'h0000_0001);
      drive(4'd1, 32'h0, 32'h0, 5'd1, 32'h214);
      go();
      chk("lw0", bus.wb_data, 32'h80FF_7F01);
      r_force = 1'b0;

      drive(4'd6, 32'h102, 32'h99, 5'd0, 32'h400);
      chk("ades_we", {31'd0, bus.dm_we}, 32'd0);
      go();
      chk("ades_valid", {31'd0, bus.exc_valid}, 32'd1);
      chk("ades_code", {27'd0, bus.exc_code}, 32'd5);
      chk("ades_vaddr", bus.exc_vaddr, 32'h102);
      chk("ades_pc", bus.exc_pc, 32'h400);
      chk("ades_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      drive(4'd2, 32'h2000, 32'h0, 5'd2, 32'h404);
      go();
      chk("adel_oor_valid", {31'd0, bus.exc_valid}, 32'd1);
      chk("adel_oor_code", {27'd0, bus.exc_code}, 32'd4);
      chk("adel_oor_vaddr", bus.exc_vaddr, 32'h2000);
      chk("adel_oor_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      drive(4'd1, 32'h1, 32'h0, 5'd2, 32'h408);
      go();
      chk("adel_mis_valid", {31'd0, bus.exc_valid}, 32'd1);
      chk("adel_mis_vaddr", bus.exc_vaddr, 32'h1);
      bus.stall = 1'b1;
      go();
      chk("exc_pulse_once", {31'd0, bus.exc_valid}, 32'd0);
      chk("exc_code_hold", {27'd0, bus.exc_code}, 32'd4);
      chk("exc_vaddr_hold", bus.exc_vaddr, 32'h1);
      bus.stall = 1'b0;

      drive(4'd1, 32'h4, 32'h0, 5'd3, 32'h500);
      go();
      chk("pre_stall_data", bus.wb_data, 32'h1234_0000);
      c0 = we_cnt;
      bus.stall = 1'b1;
      drive(4'd6, 32'h8, 32'hDEAD_BEEF, 5'd0, 32'h504);
      chk("stall_we_first", {31'd0, bus.dm_we}, 32'd1);
      go();
      chk("stall_we_c1", {31'd0, bus.dm_we}, 32'd0);
      chk("stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("stall_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
      chk("stall_wb_data", bus.wb_data, 32'h1234_0000);
      go();
      chk("stall_we_c2", {31'd0, bus.dm_we}, 32'd0);
      go();
      chk("stall_we_c3", {31'd0, bus.dm_we}, 32'd0);
      chk("stall_exc_valid", {31'd0, bus.exc_valid}, 32'd0);
      bus.stall = 1'b0;
      #1;
      chk("release_we", {31'd0, bus.dm_we}, 32'd0);
      go();
      chk("stall_we_count", we_cnt - c0, 32'd1);
      chk("release_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      drive(4'd6, 32'hC, 32'h55, 5'd0, 32'h508);
      chk("st_done_cleared", {31'd0, bus.dm_we}, 32'd1);
      go();
      drive(4'd1, 32'h8, 32'h0, 5'd4, 32'h50C);
      go();
      chk("stalled_sw_data", bus.wb_data, 32'hDEAD_BEEF);

      bus.flush = 1'b1;
      drive(4'd1, 32'h8, 32'h0, 5'd9, 32'h600);
      go();
      chk("flush_lw", {31'd0, bus.wb_valid}, 32'd0);
      drive(4'd6, 32'h8, 32'h1, 5'd0, 32'h604);
      chk("flush_sw_we", {31'd0, bus.dm_we}, 32'd0);
      bus.flush = 1'b0;
      drive(4'd1, 32'h8, 32'h0, 5'd9, 32'h608);
      go();
      chk("post_flush_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("post_flush_data", bus.wb_data, 32'hDEAD_BEEF);
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      drive(4'd6, 32'h10, 32'h77, 5'd0, 32'h60C);
      chk("flush_stall_we", {31'd0, bus.dm_we}, 32'd0);
      go();
      chk("flush_stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("flush_stall_wb_rd", {27'd0, bus.wb_rd}, 32'd9);
      bus.flush = 1'b0;
      #1;
      chk("unflush_stall_we", {31'd0, bus.dm_we}, 32'd1);
      go();
      chk("unflush_stall_we_done", {31'd0, bus.dm_we}, 32'd0);

      bus.stall = 1'b0;
      drive(4'd1, 32'h8, 32'h0, 5'd10, 32'h700);
      go();
      chk("pre_rst_wb_rd", {27'd0, bus.wb_rd}, 32'd10);
      bus.stall = 1'b1;
      drive(4'd1, 32'h4, 32'h0, 5'd5, 32'h704);
      go();
      chk("pend_wb_rd_hold", {27'd0, bus.wb_rd}, 32'd10);
      reset = 1'b1;
      go();
      chk("mrst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("mrst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
      chk("mrst_wb_data", bus.wb_data, 32'd0);
      chk("mrst_exc_valid", {31'd0, bus.exc_valid}, 32'd0);
      chk("mrst_exc_code", {27'd0, bus.exc_code}, 32'd0);
      chk("mrst_exc_vaddr", bus.exc_vaddr, 32'd0);
      chk("mrst_exc_pc", bus.exc_pc, 32'd0);
      drive(4'd6, 32'h8, 32'h1, 5'd0, 32'h708);
      chk("mrst_dm_we", {31'd0, bus.dm_we}, 32'd0);
      reset = 1'b0;
      bus.stall = 1'b0;
      bus.valid_in = 1'b0;
      go();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
